// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one single-precision multiplier among NUM_REQ clients,
// one operation in flight, with a completion timeout that answers with a quiet NaN.
`default_nettype none

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_timeout,
  output logic                 mul_input_valid,
  output logic [31:0]          mul_in_a,
  output logic [31:0]          mul_in_b,
  input  logic [31:0]          mul_data_out,
  input  logic                 mul_output_valid,
  output logic                 busy
);

  localparam int              TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]     QNAN     = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  gnt_q, gnt_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_timeout_q, resp_timeout_d;
  logic             mul_start_q, mul_start_d;
  logic             busy_q, busy_d;

  logic [ID_W-1:0]  scan_idx;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;

  // Scan starts one past the last winner so the last-served client has lowest priority.
  always_comb begin
    scan_idx = rr_ptr_q;
    win_idx  = '0;
    win_any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!win_any && req_valid[scan_idx]) begin
        win_any = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_any) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_d          = gnt_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    resp_data_d    = resp_data_q;
    tmo_cnt_d      = tmo_cnt_q;
    resp_valid_d   = resp_valid_q;
    resp_timeout_d = resp_timeout_q;
    mul_start_d    = 1'b0;
    busy_d         = busy_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
              op_a_d = req_a[32*i +: 32];
              op_b_d = req_b[32*i +: 32];
            end
          end
          gnt_d       = win_idx;
          mul_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = BUSY;
      end
      BUSY: begin
        if (mul_output_valid) begin
          resp_data_d    = mul_data_out;
          resp_timeout_d = 1'b0;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          resp_data_d    = QNAN;
          resp_timeout_d = 1'b1;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = gnt_q;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      gnt_q          <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      resp_data_q    <= '0;
      tmo_cnt_q      <= '0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      mul_start_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_q          <= gnt_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      resp_data_q    <= resp_data_d;
      tmo_cnt_q      <= tmo_cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      mul_start_q    <= mul_start_d;
      busy_q         <= busy_d;
    end
  end

  // Operands stay on the multiplier bus until the next grant replaces them.
  assign mul_in_a        = op_a_q;
  assign mul_in_b        = op_b_q;
  assign mul_input_valid = mul_start_q;
  assign resp_valid      = resp_valid_q;
  assign resp_data       = resp_data_q;
  assign resp_id         = gnt_q;
  assign resp_timeout    = resp_timeout_q;
  assign busy            = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed vectors against fp_mul_arbiter with a latency-programmable stub multiplier.
`default_nettype none

module tb_fp_mul_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int TMO  = 64;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [32*N-1:0]   req_a, req_b;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_data;
  logic [ID_W-1:0]   resp_id;
  logic              resp_timeout;
  logic              mul_input_valid;
  logic [31:0]       mul_in_a, mul_in_b, mul_data_out;
  logic              mul_output_valid;
  logic              busy;

  logic [31:0] ra [N];
  logic [31:0] rb [N];
  int          n_vec = 0;
  int          n_fail = 0;

  bit          mul_en = 1'b1;
  bit          mul_late = 1'b0;
  int          mul_lat = 0;
  logic        stub_pend, stub_ov;
  int          stub_cnt;
  logic [31:0] stub_a, stub_b, stub_q;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = ra[i];
      req_b[32*i +: 32] = rb[i];
    end
  end

  fp_mul_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_timeout(resp_timeout),
    .mul_input_valid(mul_input_valid), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
    .mul_data_out(mul_data_out), .mul_output_valid(mul_output_valid), .busy(busy)
  );

  // Known single-precision products for the operand pairs used below.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'h3F800000, 32'hC0A00000}: return 32'hC0A00000;
      {32'h80000000, 32'h3F800000}: return 32'h80000000;
      {32'h40800000, 32'h3E800000}: return 32'h3F800000;
      {32'h7F7FFFFF, 32'h40000000}: return 32'h7F800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_pend <= 1'b0;
      stub_cnt  <= 0;
      stub_ov   <= 1'b0;
      stub_q    <= '0;
      stub_a    <= '0;
      stub_b    <= '0;
    end else begin
      stub_ov <= 1'b0;
      if (mul_input_valid && mul_en) begin
        stub_pend <= 1'b1;
        stub_cnt  <= mul_lat;
        stub_a    <= mul_in_a;
        stub_b    <= mul_in_b;
      end else if (stub_pend) begin
        if (stub_cnt == 0) begin
          stub_pend <= 1'b0;
          stub_ov   <= 1'b1;
          stub_q    <= fmul(stub_a, stub_b);
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  assign mul_output_valid = stub_ov | mul_late;
  assign mul_data_out     = stub_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int gid);
    int cyc;
    cyc = 0;
    gid = -1;
    #1;
    while (req_ready == '0 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("grant_onehot", 64'($countones(req_ready)), 64'd1);
    for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
  endtask

  task automatic issue_check(input int gid, input bit keep);
    @(negedge clk);
    check("issue_pulse", {63'd0, mul_input_valid}, 64'd1);
    check("issue_ops", {mul_in_a, mul_in_b}, {ra[gid], rb[gid]});
    if (!keep) req_valid[gid] = 1'b0;
  endtask

  task automatic wait_resp();
    int cyc;
    cyc = 0;
    while (!resp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("resp_wait", {63'd0, resp_valid}, 64'd1);
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", {62'd0, resp_valid, busy}, 64'd0);
  endtask

  task automatic serve(input int exp_id, input logic [31:0] exp_data, input bit exp_tmo, input bit keep);
    int gid;
    wait_ready(gid);
    check("grant_id", 64'(gid), 64'(exp_id));
    if (gid < 0) return;
    issue_check(gid, keep);
    wait_resp();
    check("resp", {29'd0, resp_id, resp_timeout, resp_data}, {29'd0, ID_W'(exp_id), exp_tmo, exp_data});
    accept();
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          tmo;
    int          lat;
  } vec_t;

  vec_t vt [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid;
    int cnt;
    vt[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 2};
    vt[1] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 0};
    vt[2] = '{3, 32'h3F800000, 32'hC0A00000, 32'hC0A00000, 1'b0, 5};
    vt[3] = '{2, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1};
    vt[4] = '{1, 32'h40800000, 32'h3E800000, 32'h3F800000, 1'b0, 62};
    vt[5] = '{0, 32'h7F7FFFFF, 32'h40000000, 32'h7FC00000, 1'b1, 63};
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end

    @(negedge clk);
    check("reset_ctl", {22'd0, req_ready, resp_valid, resp_id, resp_timeout, mul_input_valid, busy, mul_in_b}, 64'd0);
    check("reset_data", {resp_data, mul_in_a}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-requester table; vt[4]/vt[5] straddle the last BUSY cycle.
    for (int v = 0; v < 6; v++) begin
      ra[vt[v].id] = vt[v].a;
      rb[vt[v].id] = vt[v].b;
      mul_lat = vt[v].lat;
      req_valid = '0;
      req_valid[vt[v].id] = 1'b1;
      serve(vt[v].id, vt[v].exp, vt[v].tmo, 1'b0);
    end

    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Two simultaneous requests from rr_ptr=0: index 2 wins before index 0.
    ra[0] = 32'h40000000; rb[0] = 32'h40400000;
    ra[1] = 32'h3FC00000; rb[1] = 32'h3FC00000;
    ra[2] = 32'h3F800000; rb[2] = 32'hC0A00000;
    ra[3] = 32'h80000000; rb[3] = 32'h3F800000;
    mul_lat = 1;
    req_valid = 4'b0101;
    #1;
    check("rr_first", {60'd0, req_ready}, 64'h4);
    serve(2, 32'hC0A00000, 1'b0, 1'b0);
    serve(0, 32'h40C00000, 1'b0, 1'b0);

    // All four held high: strict rotation 1,2,3,0,...
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      case ((k + 1) % 4)
        0: serve(0, 32'h40C00000, 1'b0, 1'b1);
        1: serve(1, 32'h40100000, 1'b0, 1'b1);
        2: serve(2, 32'hC0A00000, 1'b0, 1'b1);
        default: serve(3, 32'h80000000, 1'b0, 1'b1);
      endcase
    end
    req_valid = '0;
    @(negedge clk);

    // Response back-pressure: data held, no grant to the waiting client.
    mul_lat = 3;
    req_valid = 4'b0010;
    wait_ready(gid);
    check("bp_grant", 64'(gid), 64'd1);
    issue_check(1, 1'b0);
    req_valid[0] = 1'b1;
    wait_resp();
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", {24'd0, req_ready, resp_valid, resp_id, resp_timeout, resp_data},
            {24'd0, 4'b0000, 1'b1, 2'd1, 1'b0, 32'h40100000});
      @(negedge clk);
    end
    accept();
    serve(0, 32'h40C00000, 1'b0, 1'b0);

    // Multiplier never completes.
    mul_en = 1'b0;
    ra[3] = 32'h40000000; rb[3] = 32'h40400000;
    req_valid = 4'b1000;
    wait_ready(gid);
    check("tmo_grant", 64'(gid), 64'd3);
    issue_check(3, 1'b0);
    @(negedge clk);
    check("tmo_busy", {62'd0, busy, mul_input_valid}, 64'd2);
    cnt = 2;
    while (!resp_valid && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo_latency", 64'(cnt), 64'(TMO + 2));
    check("tmo_resp", {29'd0, resp_id, resp_timeout, resp_data}, {29'd0, 2'd3, 1'b1, 32'h7FC00000});
    mul_late = 1'b1;
    @(negedge clk);
    mul_late = 1'b0;
    check("late_in_resp", {28'd0, resp_valid, resp_id, resp_timeout, resp_data}, {28'd0, 1'b1, 2'd3, 1'b1, 32'h7FC00000});
    accept();
    mul_late = 1'b1;
    @(negedge clk);
    mul_late = 1'b0;
    check("late_in_idle", {61'd0, busy, resp_valid, mul_input_valid}, 64'd0);
    mul_en = 1'b1;

    // Asynchronous reset in the middle of BUSY.
    ra[0] = 32'h40000000; rb[0] = 32'h40400000;
    mul_lat = 20;
    req_valid = 4'b0001;
    wait_ready(gid);
    issue_check(0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_ctl", {22'd0, req_ready, resp_valid, resp_id, resp_timeout, mul_input_valid, busy, mul_in_b}, 64'd0);
    check("rst_data", {resp_data, mul_in_a}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {62'd0, resp_valid, busy}, 64'd0);
    mul_lat = 2;
    req_valid = 4'b0001;
    serve(0, 32'h40C00000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
